// File: rtl/uart8_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : uart8_receiver_if
// Brief    : Receive-side bus of the 8N1 UART receiver: oversample tick and
//            serial line in, received byte with done/err/busy status out.
// Revision : 1.0 - initial release
// ============================================================================
interface uart8_receiver_if;
  logic       en;    // oversample tick, one clk wide
  logic       in;    // asynchronous serial line, idle high
  logic [7:0] out;   // last correctly received byte
  logic       done;  // one-cycle pulse: new byte on out
  logic       err;   // one-cycle pulse: framing error
  logic       busy;  // frame in progress

  // Stimulus / line side: drives the tick and serial line, observes results.
  modport master (
    output en,
    output in,
    input  out,
    input  done,
    input  err,
    input  busy
  );

  // Receiver side.
  modport slave (
    input  en,
    input  in,
    output out,
    output done,
    output err,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/uart8_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart8_receiver
// Brief    : 8N1 UART receiver with OVERSAMPLE-x tick sampling. Start bit is
//            validated at its mid-point, data bits are sampled LSB first at
//            their mid-points, and a low stop bit raises a single framing
//            error that is held off until the line returns high.
// Revision : 1.0 - initial release
// ============================================================================
module uart8_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input wire logic        clk,
  input wire logic        rst,
  uart8_receiver_if.slave bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    RECOVER   = 3'd4
  } state_t;

  logic              rx_meta;
  logic              rx_s;
  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [2:0]        bitn;
  logic [7:0]        shift;
  logic [7:0]        byte_q;
  logic              done_q;
  logic              err_q;
  logic              busy_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.in;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM; every status output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tick   <= '0;
      bitn   <= 3'd0;
      shift  <= 8'h00;
      byte_q <= 8'h00;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      // Strobes last exactly one clk regardless of en.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.en) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START_BIT;
              tick   <= '0;
              busy_q <= 1'b1;
            end
          end

          START_BIT: begin
            if (tick == HALF_LAST) begin
              tick <= '0;
              if (rx_s) begin
                // Line went back high before mid-start: treat as a glitch.
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                state <= DATA_BITS;
                bitn  <= 3'd0;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end

          DATA_BITS: begin
            if (tick == FULL_LAST) begin
              shift <= {rx_s, shift[7:1]};
              tick  <= '0;
              bitn  <= bitn + 3'd1;
              if (bitn == 3'd7) begin
                state <= STOP_BIT;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end

          STOP_BIT: begin
            if (tick == FULL_LAST) begin
              tick   <= '0;
              busy_q <= 1'b0;
              if (rx_s) begin
                byte_q <= shift;
                done_q <= 1'b1;
                state  <= IDLE;
              end else begin
                // Low stop bit: report once, then wait out a break.
                err_q <= 1'b1;
                state <= RECOVER;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end

          RECOVER: begin
            if (rx_s) begin
              state <= IDLE;
            end
          end

          default: begin
            state  <= IDLE;
            tick   <= '0;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out  = byte_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart8_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart8_receiver
// Brief    : Scoreboard bench for uart8_receiver: frames are driven at exact
//            baud (en every 4 clk, 16x oversampling), expected bytes queued
//            on send and popped on each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart8_receiver;

  localparam int OS      = 16;
  localparam int BIT_CLK = OS * 4;

  logic clk;
  logic rst;

  uart8_receiver_if bus ();

  uart8_receiver #(.OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         errors   = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         pushed   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_out = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report any mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Oversample tick: one clk high out of every four.
  initial begin
    bus.en = 1'b0;
    forever begin
      repeat (3) begin
        @(negedge clk);
        bus.en = 1'b0;
      end
      @(negedge clk);
      bus.en = 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on done, tracks err and out stability.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      last_out = 8'h00;
    end else begin
      if (bus.done && bus.err) check("done_err_excl", 1, 0);
      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_done", bus.done, 0);
        end else begin
          check("rx_byte", bus.out, exp_q.pop_front());
        end
        last_out = bus.out;
      end else if (bus.out !== last_out) begin
        check("out_stable", bus.out, last_out);
        last_out = bus.out;
      end
      if (bus.err) err_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    bus.in = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back(b);
      pushed++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        bus.in = b[i];
        wait_clk(BIT_CLK / 2);
        check("busy_in_frame", bus.busy, 1);
        wait_clk(BIT_CLK / 2);
      end else begin
        drive_bit(b[i]);
      end
    end
    drive_bit(stop);
  endtask

  // Watchdog: every stimulus wait is fixed length, this only guards hangs.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    logic [7:0] ab;
    rst    = 1'b1;
    bus.in = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    check("rst_out",  bus.out,  8'h00);
    check("rst_done", bus.done, 0);
    check("rst_err",  bus.err,  0);
    check("rst_busy", bus.busy, 0);

    // Idle line for 100 bit periods.
    wait_clk(100 * BIT_CLK);
    check("idle_busy", bus.busy, 0);
    check("idle_done_cnt", done_cnt, 0);
    check("idle_err_cnt", err_cnt, 0);
    check("idle_out", bus.out, 8'h00);

    // Two frames with a little idle between.
    send_frame(8'h55, 1'b1);
    check("busy_after_55", bus.busy, 0);
    drive_bit(1'b1);
    send_frame(8'hA5, 1'b1);
    check("busy_after_A5", bus.busy, 0);
    check("out_A5", bus.out, 8'hA5);
    drive_bit(1'b1);

    // Back-to-back, no idle between stop and next start.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    check("out_FF", bus.out, 8'hFF);
    drive_bit(1'b1);

    // Three-tick low glitch on the idle line.
    d0 = done_cnt;
    e0 = err_cnt;
    bus.in = 1'b0;
    wait_clk(12);
    bus.in = 1'b1;
    wait_clk(4);
    check("glitch_busy_hi", bus.busy, 1);
    wait_clk(48);
    check("glitch_busy_lo", bus.busy, 0);
    check("glitch_no_done", done_cnt, d0);
    check("glitch_no_err", err_cnt, e0);
    drive_bit(1'b1);
    send_frame(8'h3C, 1'b1);
    check("out_3C", bus.out, 8'h3C);
    drive_bit(1'b1);

    // Framing error followed by a long break.
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(8'h81, 1'b0);
    bus.in = 1'b0;
    wait_clk(20 * BIT_CLK);
    check("ferr_one_err", err_cnt, e0 + 1);
    check("ferr_no_done", done_cnt, d0);
    check("ferr_out_kept", bus.out, 8'h3C);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h7E, 1'b1);
    check("out_7E", bus.out, 8'h7E);
    drive_bit(1'b1);

    // Reset in the middle of data bit 4; aborted frame must vanish.
    d0 = done_cnt;
    e0 = err_cnt;
    ab = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(ab[i]);
    bus.in = ab[4];
    wait_clk(BIT_CLK / 2);
    rst    = 1'b1;
    bus.in = 1'b1;
    wait_clk(1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_out", bus.out, 8'h00);
    rst = 1'b0;
    wait_clk(20 * BIT_CLK);
    check("midrst_no_done", done_cnt, d0);
    check("midrst_no_err", err_cnt, e0);
    send_frame(8'hC3, 1'b1);
    check("out_C3", bus.out, 8'hC3);
    drive_bit(1'b1);

    check("total_done", done_cnt, pushed);
    check("total_err", err_cnt, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
